// File: rtl/mnist_frame_ctrl_if.sv
// Frame-controller bus: UART RX bytes in, accelerator pixel/result path, UART TX and display out.
// master = frame controller, slave = surrounding system (UART, accelerator, display).
interface mnist_frame_ctrl_if;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        acc_clear;
  logic        acc_valid;
  logic [7:0]  acc_pixel;
  logic [31:0] acc_result;
  logic        acc_result_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [3:0]  disp_num;
  logic        frame_busy;
  logic        err_flag;

  modport master (
    input  rx_byte, rx_valid, acc_result, acc_result_valid, tx_busy,
    output acc_clear, acc_valid, acc_pixel, tx_data, tx_start, disp_num, frame_busy, err_flag
  );

  modport slave (
    output rx_byte, rx_valid, acc_result, acc_result_valid, tx_busy,
    input  acc_clear, acc_valid, acc_pixel, tx_data, tx_start, disp_num, frame_busy, err_flag
  );
endinterface

// File: rtl/mnist_frame_ctrl.sv
// MNIST frame sequencer: sync hunt, pixel forwarding, result wait, one TX byte per frame.
// Pixels reach the accelerator 1 cycle after rx_valid; tx_start waits for tx_busy low. Optional: CHECKSUM_EN.
module mnist_frame_ctrl #(
  parameter int         PIX_NUM         = 784,
  parameter logic [7:0] SYNC_BYTE       = 8'hAA,
  parameter int         RX_TIMEOUT_CYC  = 5_000_000,
  parameter int         RES_TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] ERR_CODE        = 8'hEE
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  mnist_frame_ctrl_if.master bus
);

  localparam int PIX_W   = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
  localparam int TMR_MAX = (RX_TIMEOUT_CYC > RES_TIMEOUT_CYC) ? RX_TIMEOUT_CYC : RES_TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_NUM - 1);
  localparam logic [TMR_W-1:0] RX_LIM   = TMR_W'(RX_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] RES_LIM  = TMR_W'(RES_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
`ifdef CHECKSUM_EN
    S_CHK,
`endif
    S_WAIT_RES,
    S_SEND,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PIX_W-1:0] r_pix_cnt;
  logic [TMR_W-1:0] r_tmr;
  logic [7:0]       r_res;
  logic             r_acc_clear;
  logic             r_acc_valid;
  logic [7:0]       r_acc_pixel;
  logic [7:0]       r_tx_data;
  logic [3:0]       r_disp;
  logic             r_err;
  logic             r_ck_bad;

  logic             w_sync;
  logic             w_tx_start;
  logic [7:0]       w_tx_byte;
  logic             w_tmr_clr;
  logic             w_unused_res;

  assign w_unused_res = ^bus.acc_result[31:8];
  assign w_sync       = bus.rx_valid && (bus.rx_byte == SYNC_BYTE);

`ifdef CHECKSUM_EN
  logic [7:0] r_sum;
`else
  assign r_ck_bad = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    w_tx_byte  = r_res;
    unique case (r_state)
      S_IDLE: begin
        if (w_sync) w_next = S_RECV;
      end
      S_RECV: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (bus.rx_valid) begin
          if (r_pix_cnt == PIX_LAST) begin
`ifdef CHECKSUM_EN
            w_next = S_CHK;
`else
            w_next = S_WAIT_RES;
`endif
          end
        end else if (r_tmr >= RX_LIM) begin
          w_next = S_ERR;
        end
      end
`ifdef CHECKSUM_EN
      S_CHK: begin
        if (bus.rx_valid)         w_next = S_WAIT_RES;
        else if (r_tmr >= RX_LIM) w_next = S_ERR;
      end
`endif
      S_WAIT_RES: begin
        if (bus.acc_result_valid) begin
          if ((bus.acc_result[7:0] > 8'd9) || r_ck_bad) w_next = S_ERR;
          else                                          w_next = S_SEND;
        end else if (r_tmr >= RES_LIM) begin
          w_next = S_ERR;
        end
      end
      S_SEND: begin
        if (!bus.tx_busy) begin
          w_tx_start = 1'b1;
          w_next     = S_IDLE;
        end
      end
      S_ERR: begin
        w_tx_byte = ERR_CODE;
        if (!bus.tx_busy) begin
          w_tx_start = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Gap/result timer restarts on every state change and on each in-frame byte.
  always_comb begin
    w_tmr_clr = (w_next != r_state) || (r_state == S_IDLE);
    if (bus.rx_valid && (r_state == S_RECV)) w_tmr_clr = 1'b1;
`ifdef CHECKSUM_EN
    if (bus.rx_valid && (r_state == S_CHK))  w_tmr_clr = 1'b1;
`endif
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tmr <= '0;
    end else if (w_tmr_clr) begin
      r_tmr <= '0;
    end else if (r_tmr != {TMR_W{1'b1}}) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pix_cnt   <= '0;
      r_res       <= '0;
      r_acc_clear <= 1'b0;
      r_acc_valid <= 1'b0;
      r_acc_pixel <= '0;
      r_tx_data   <= '0;
      r_disp      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_acc_clear <= (r_state == S_IDLE) && w_sync;
      r_acc_valid <= (r_state == S_RECV) && bus.rx_valid;
      if ((r_state == S_IDLE) && w_sync) r_pix_cnt <= '0;
      if ((r_state == S_RECV) && bus.rx_valid) begin
        r_acc_pixel <= bus.rx_byte;
        r_pix_cnt   <= r_pix_cnt + 1'b1;
      end
      if ((r_state == S_WAIT_RES) && bus.acc_result_valid) r_res <= bus.acc_result[7:0];
      if (w_tx_start) begin
        r_tx_data <= w_tx_byte;
        if (r_state == S_SEND) begin
          r_disp <= r_res[3:0];
          r_err  <= 1'b0;
        end else begin
          r_err  <= 1'b1;
        end
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sum    <= '0;
      r_ck_bad <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_sync) begin
        r_sum    <= '0;
        r_ck_bad <= 1'b0;
      end
      if ((r_state == S_RECV) && bus.rx_valid) r_sum <= r_sum + bus.rx_byte;
      if ((r_state == S_CHK) && bus.rx_valid)  r_ck_bad <= (bus.rx_byte != r_sum);
    end
  end
`endif

  assign bus.acc_clear  = r_acc_clear;
  assign bus.acc_valid  = r_acc_valid;
  assign bus.acc_pixel  = r_acc_pixel;
  assign bus.tx_start   = w_tx_start;
  // tx_data shows the outgoing byte during the strobe and holds it afterwards.
  assign bus.tx_data    = w_tx_start ? w_tx_byte : r_tx_data;
  assign bus.disp_num   = r_disp;
  assign bus.frame_busy = (r_state != S_IDLE);
  assign bus.err_flag   = r_err;

endmodule
